// File: rtl/pat_pkg.sv
// Shared types and sizing helpers for the gradient pattern source.
// Latency: n/a (types only). Backpressure: n/a.
package pat_pkg;

   typedef enum logic {
      GRAD_SAW = 1'b0,
      GRAD_TRI = 1'b1
   } pat_grad_mode_e;

   localparam int RGB_DEF_WIDTH = 8;

   // Default-width pixel; parametrised blocks build their own with the same layout.
   typedef struct packed {
      logic [RGB_DEF_WIDTH-1:0] r;
      logic [RGB_DEF_WIDTH-1:0] g;
      logic [RGB_DEF_WIDTH-1:0] b;
   } rgb_t;

   function automatic int idx_width(input int num_leds);
      return (num_leds <= 2) ? 1 : $clog2(num_leds);
   endfunction

   function automatic int grad_step(input int num_leds, input int phase_width);
      return (2 ** phase_width) / num_leds;
   endfunction

endpackage

// File: rtl/pat_lerp.sv
// One-channel interpolator: registers c0 and (c1-c0)*t, then adds the floored product.
// Latency: 1 register, result combinational after it. Backpressure: none.
module pat_lerp #(
   parameter int COLOR_WIDTH = 8,
   parameter int PHASE_WIDTH = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [COLOR_WIDTH-1:0] c0,
   input  logic [COLOR_WIDTH-1:0] c1,
   input  logic [PHASE_WIDTH-1:0] t,
   output logic [COLOR_WIDTH-1:0] ch
);

   localparam int PW = COLOR_WIDTH + PHASE_WIDTH + 2;

   logic signed [COLOR_WIDTH:0] d;
   logic signed [PW-1:0]        prod;
   logic signed [PW-1:0]        prod_q;
   logic [COLOR_WIDTH-1:0]      c0_q;

   assign d    = $signed({1'b0, c1}) - $signed({1'b0, c0});
   assign prod = d * $signed({1'b0, t});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '0;
         c0_q   <= '0;
      end else begin
         prod_q <= prod;
         c0_q   <= c0;
      end
   end

   // True sum always lies between c0 and c1, so modulo-width addition is exact.
   assign ch = COLOR_WIDTH'(prod_q >>> PHASE_WIDTH) + c0_q;

endmodule

// File: rtl/pat_gradient_anim.sv
// Animated two-colour gradient source; optional gamma stage under PAT_GRADIENT_GAMMA_EN.
// Latency 3 cycles (4 with PAT_GRADIENT_GAMMA_EN), one request per cycle, no backpressure.
module pat_gradient_anim
   import pat_pkg::*;
#(
   parameter int NUM_LEDS    = 20,
   parameter int COLOR_WIDTH = 8,
   parameter int PHASE_WIDTH = 10,
   localparam int IDX_W      = idx_width(NUM_LEDS)
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic                     frame_start_in,
   input  logic [3*COLOR_WIDTH-1:0] cfg_color0_in,
   input  logic [3*COLOR_WIDTH-1:0] cfg_color1_in,
   input  logic [PHASE_WIDTH-1:0]   cfg_speed_in,
   input  logic                     cfg_mode_in,
   input  logic                     req_valid_in,
   input  logic [IDX_W-1:0]         req_index_in,
   output logic [COLOR_WIDTH-1:0]   red_out,
   output logic [COLOR_WIDTH-1:0]   green_out,
   output logic [COLOR_WIDTH-1:0]   blue_out,
   output logic [IDX_W-1:0]         index_out,
   output logic                     color_valid_out
);

   localparam int CW   = COLOR_WIDTH;
   localparam int P    = PHASE_WIDTH;
   localparam int STEP = grad_step(NUM_LEDS, PHASE_WIDTH);

   typedef struct packed {
      logic [CW-1:0] r;
      logic [CW-1:0] g;
      logic [CW-1:0] b;
   } pix_t;

   pix_t           c0_sh, c1_sh;
   pat_grad_mode_e mode_sh;
   logic [P-1:0]   offset;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         c0_sh   <= '0;
         c1_sh   <= '0;
         mode_sh <= GRAD_SAW;
         offset  <= '0;
      end else if (frame_start_in) begin
         c0_sh   <= pix_t'(cfg_color0_in);
         c1_sh   <= pix_t'(cfg_color1_in);
         mode_sh <= pat_grad_mode_e'(cfg_mode_in);
         offset  <= offset + cfg_speed_in;
      end
   end

   // S1: phase from the shadow state; config travels with the request so a
   // frame strobe cannot alter requests already in flight.
   logic [P-1:0]   phase_s1;
   logic           oor_s1;
   logic           s1_vld, s1_oor;
   logic [IDX_W-1:0] s1_idx;
   logic [P-1:0]   s1_phase;
   pat_grad_mode_e s1_mode;
   pix_t           s1_c0, s1_c1;

   assign phase_s1 = P'(32'(req_index_in) * STEP) + offset;
   assign oor_s1   = 32'(req_index_in) >= NUM_LEDS;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         s1_vld   <= 1'b0;
         s1_oor   <= 1'b0;
         s1_idx   <= '0;
         s1_phase <= '0;
         s1_mode  <= GRAD_SAW;
         s1_c0    <= '0;
         s1_c1    <= '0;
      end else begin
         s1_vld   <= req_valid_in;
         s1_oor   <= oor_s1;
         s1_idx   <= req_index_in;
         s1_phase <= phase_s1;
         s1_mode  <= mode_sh;
         s1_c0    <= c0_sh;
         s1_c1    <= c1_sh;
      end
   end

   // S2: shape the phase; triangle mirrors the upper half back down.
   logic [P-1:0] tri_t, t_s2;
   assign tri_t = s1_phase[P-1] ? (~s1_phase << 1) : (s1_phase << 1);
   assign t_s2  = (s1_mode == GRAD_TRI) ? tri_t : s1_phase;

   logic             s2_vld, s2_oor;
   logic [IDX_W-1:0] s2_idx;
   pix_t             ch_s3;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         s2_vld <= 1'b0;
         s2_oor <= 1'b0;
         s2_idx <= '0;
      end else begin
         s2_vld <= s1_vld;
         s2_oor <= s1_oor;
         s2_idx <= s1_idx;
      end
   end

   pat_lerp #(.COLOR_WIDTH(CW), .PHASE_WIDTH(P)) u_lerp_r (
      .clk(clk_in), .rst_n(rst_n_in), .c0(s1_c0.r), .c1(s1_c1.r), .t(t_s2), .ch(ch_s3.r)
   );
   pat_lerp #(.COLOR_WIDTH(CW), .PHASE_WIDTH(P)) u_lerp_g (
      .clk(clk_in), .rst_n(rst_n_in), .c0(s1_c0.g), .c1(s1_c1.g), .t(t_s2), .ch(ch_s3.g)
   );
   pat_lerp #(.COLOR_WIDTH(CW), .PHASE_WIDTH(P)) u_lerp_b (
      .clk(clk_in), .rst_n(rst_n_in), .c0(s1_c0.b), .c1(s1_c1.b), .t(t_s2), .ch(ch_s3.b)
   );

   // S3: result register holds its value while no request completes.
   pix_t             s3_pix;
   logic [IDX_W-1:0] s3_idx;
   logic             s3_vld;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         s3_pix <= '0;
         s3_idx <= '0;
         s3_vld <= 1'b0;
      end else begin
         s3_vld <= s2_vld;
         if (s2_vld) begin
            s3_pix <= s2_oor ? '0 : ch_s3;
            s3_idx <= s2_idx;
         end
      end
   end

   pix_t             out_pix;
   logic [IDX_W-1:0] out_idx;
   logic             out_vld;

`ifdef PAT_GRADIENT_GAMMA_EN
   function automatic logic [CW-1:0] gamma(input logic [CW-1:0] c);
      return CW'(({{CW{1'b0}}, c} * {{CW{1'b0}}, c}) >> CW);
   endfunction

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         out_pix <= '0;
         out_idx <= '0;
         out_vld <= 1'b0;
      end else begin
         out_vld <= s3_vld;
         if (s3_vld) begin
            out_pix.r <= gamma(s3_pix.r);
            out_pix.g <= gamma(s3_pix.g);
            out_pix.b <= gamma(s3_pix.b);
            out_idx   <= s3_idx;
         end
      end
   end
`else
   assign out_pix = s3_pix;
   assign out_idx = s3_idx;
   assign out_vld = s3_vld;
`endif

   assign red_out         = out_pix.r;
   assign green_out       = out_pix.g;
   assign blue_out        = out_pix.b;
   assign index_out       = out_idx;
   assign color_valid_out = out_vld;

endmodule

// File: tb/tb_pat_gradient_anim.sv
// Directed vector bench for pat_gradient_anim (default parameters, gamma off).
module tb_pat_gradient_anim;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        frame_start_in;
   logic [23:0] cfg_color0_in, cfg_color1_in;
   logic [9:0]  cfg_speed_in;
   logic        cfg_mode_in;
   logic        req_valid_in;
   logic [4:0]  req_index_in;
   logic [7:0]  red_out, green_out, blue_out;
   logic [4:0]  index_out;
   logic        color_valid_out;

   int checks   = 0;
   int failures = 0;

   always #5 clk_in = ~clk_in;

   pat_gradient_anim dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .frame_start_in(frame_start_in),
      .cfg_color0_in(cfg_color0_in), .cfg_color1_in(cfg_color1_in),
      .cfg_speed_in(cfg_speed_in), .cfg_mode_in(cfg_mode_in),
      .req_valid_in(req_valid_in), .req_index_in(req_index_in),
      .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
      .index_out(index_out), .color_valid_out(color_valid_out)
   );

   typedef struct {
      bit          frame;
      logic [23:0] c0;
      logic [23:0] c1;
      logic [9:0]  speed;
      bit          mode;
      int          idx;
      int          er, eg, eb;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic apply_frame(input logic [23:0] c0, input logic [23:0] c1,
                              input logic [9:0] speed, input bit mode);
      cfg_color0_in  = c0;
      cfg_color1_in  = c1;
      cfg_speed_in   = speed;
      cfg_mode_in    = mode;
      frame_start_in = 1'b1;
      step();
      frame_start_in = 1'b0;
   endtask

   // One request; checks valid rises exactly on the third cycle.
   task automatic do_req(input string name, input int idx);
      req_valid_in = 1'b1;
      req_index_in = 5'(idx);
      step();
      req_valid_in = 1'b0;
      check({name, " valid@1"}, int'(color_valid_out), 0);
      step();
      check({name, " valid@2"}, int'(color_valid_out), 0);
      step();
      check({name, " valid@3"}, int'(color_valid_out), 1);
   endtask

   initial begin
      bit started, order_ok, mono_ok, gap_ok;
      int nvld, prev_red, exp_idx;

      rst_n_in = 1'b0;
      frame_start_in = 1'b0;
      cfg_color0_in = '0;
      cfg_color1_in = '0;
      cfg_speed_in = '0;
      cfg_mode_in = 1'b0;
      req_valid_in = 1'b0;
      req_index_in = '0;

      //          frame c0        c1        speed   mode idx  r    g    b
      vecs[0]  = '{1, 24'h000000, 24'hFF0000, 10'd0,   0,  0,   0,   0,   0};
      vecs[1]  = '{0, 24'h000000, 24'hFF0000, 10'd0,   0,  10,  127, 0,   0};
      vecs[2]  = '{0, 24'h000000, 24'hFF0000, 10'd0,   0,  19,  241, 0,   0};
      vecs[3]  = '{1, 24'h000000, 24'hFF0000, 10'd0,   1,  10,  254, 0,   0};
      vecs[4]  = '{0, 24'h000000, 24'hFF0000, 10'd0,   1,  0,   0,   0,   0};
      vecs[5]  = '{1, 24'h000000, 24'hFF0000, 10'd512, 0,  0,   127, 0,   0};
      vecs[6]  = '{1, 24'h000000, 24'hFF0000, 10'd512, 0,  0,   0,   0,   0};
      vecs[7]  = '{1, 24'h000000, 24'hFF0000, 10'h3FF, 0,  0,   254, 0,   0};
      vecs[8]  = '{1, 24'hFF0000, 24'h000000, 10'd1,   0,  10,  127, 0,   0};
      vecs[9]  = '{1, 24'h102030, 24'h30F010, 10'd0,   0,  10,  31,  135, 32};
      vecs[10] = '{1, 24'h102030, 24'h30F010, 10'd0,   1,  15,  32,  136, 31};
      vecs[11] = '{0, 24'h102030, 24'h30F010, 10'd0,   1,  25,  0,   0,   0};

      #3;
      check("reset red", int'(red_out), 0);
      check("reset green", int'(green_out), 0);
      check("reset blue", int'(blue_out), 0);
      check("reset index", int'(index_out), 0);
      check("reset valid", int'(color_valid_out), 0);
      step();
      step();
      rst_n_in = 1'b1;
      step();

      for (int i = 0; i < 12; i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         if (vecs[i].frame)
            apply_frame(vecs[i].c0, vecs[i].c1, vecs[i].speed, vecs[i].mode);
         do_req(nm, vecs[i].idx);
         check({nm, " red"}, int'(red_out), vecs[i].er);
         check({nm, " green"}, int'(green_out), vecs[i].eg);
         check({nm, " blue"}, int'(blue_out), vecs[i].eb);
         check({nm, " index"}, int'(index_out), vecs[i].idx);
      end

      // Back-to-back sweep on a reversed gradient.
      apply_frame(24'hFF0000, 24'h000000, 10'd0, 1'b0);
      nvld = 0; prev_red = 256; exp_idx = 0;
      started = 0; order_ok = 1; mono_ok = 1; gap_ok = 1;
      for (int k = 1; k <= 24; k++) begin
         req_valid_in = (k <= 20);
         req_index_in = 5'((k - 1) % 20);
         step();
         if (color_valid_out) begin
            if (k < 3 || k > 22) gap_ok = 0;
            nvld++;
            if (int'(index_out) != exp_idx) order_ok = 0;
            if (int'(red_out) > prev_red) mono_ok = 0;
            if (exp_idx == 0) check("sweep first red", int'(red_out), 255);
            if (exp_idx == 19) check("sweep last red", int'(red_out), 13);
            prev_red = int'(red_out);
            exp_idx++;
            started = 1;
         end else if (started && k <= 22) begin
            gap_ok = 0;
         end
      end
      req_valid_in = 1'b0;
      check("sweep valid count", nvld, 20);
      check("sweep timing", int'(gap_ok), 1);
      check("sweep order", int'(order_ok), 1);
      check("sweep non-increasing", int'(mono_ok), 1);

      // Unstrobed config change must be invisible.
      cfg_color1_in = 24'h00FF00;
      do_req("shadow", 10);
      check("shadow red", int'(red_out), 127);
      check("shadow green", int'(green_out), 0);

      // Request coincident with the strobe sees the old offset and colours.
      cfg_speed_in   = 10'd512;
      frame_start_in = 1'b1;
      req_valid_in   = 1'b1;
      req_index_in   = 5'd0;
      step();
      frame_start_in = 1'b0;
      step();
      req_valid_in = 1'b0;
      check("coinc valid@2", int'(color_valid_out), 0);
      step();
      check("coinc old valid", int'(color_valid_out), 1);
      check("coinc old red", int'(red_out), 255);
      check("coinc old green", int'(green_out), 0);
      step();
      check("coinc new valid", int'(color_valid_out), 1);
      check("coinc new red", int'(red_out), 127);
      check("coinc new green", int'(green_out), 127);
      step();
      check("hold valid", int'(color_valid_out), 0);
      check("hold red", int'(red_out), 127);

      // Reset with two requests in flight.
      req_valid_in = 1'b1;
      req_index_in = 5'd5;
      step();
      req_index_in = 5'd6;
      step();
      req_valid_in = 1'b0;
      rst_n_in = 1'b0;
      #1;
      check("rst red", int'(red_out), 0);
      check("rst green", int'(green_out), 0);
      check("rst valid", int'(color_valid_out), 0);
      step();
      rst_n_in = 1'b1;
      nvld = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (color_valid_out) nvld++;
      end
      check("rst dropped valids", nvld, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
